sbus_uart_rx: RTL and testbench
===============================

# sbus_uart_rx

Serial receiver for Futaba S.Bus-style UART frames: 100 kbit/s, 8 data bits, even parity, 2 stop bits, idle-high line. It deserialises one 11-bit frame at a time and presents the raw payload (data, parity and both stop bits) together with parity-error, frame-error and break flags. It sits directly behind the S.Bus input pin and feeds the channel decoder.

## Interface
- `BIT_RATE`, 100000: line bit rate in bit/s.
- `CLK_HZ`, 50000000: system clock frequency in Hz; `CYCLES_PER_BIT = CLK_HZ/BIT_RATE` (500).
- `DATA_BITS`, 8: data bits per frame, LSB first.
- `PARITY_BIT`, 1: number of parity bits (even parity).
- `STOP_BITS`, 2: number of stop bits.
- `PAYLOAD_BITS`, `DATA_BITS+PARITY_BIT+STOP_BITS` (11): width of `uart_rx_data`.
- `clk`  in  1  system clock; one clock domain.
- `resetn`  in  1  asynchronous, active-low reset.
- `uart_rxd`  in  1  serial line, asynchronous, idle high.
- `uart_rx_en`  in  1  receive enable.
- `uart_rx_data`  out  11  last received payload: [7:0] data, [8] parity bit, [10:9] stop bits.
- `uart_rx_valid`  out  1  one-cycle pulse when a new frame is in `uart_rx_data`.
- `uart_rx_pe`  out  1  parity error of the last frame.
- `uart_rx_fe`  out  1  frame error of the last frame (a stop bit sampled low).
- `uart_rx_break`  out  1  the last frame was a break (start, data, parity and stop bits all low).

## Operation
- `uart_rxd` passes through a 2-flop synchroniser; all decisions use the synchronised value.
- FSM states are IDLE, START, DATA (8 bits), PARITY, STOP (2 bits), and DONE.
- IDLE: on a synchronised falling edge with `uart_rx_en`=1, clear the bit counter and enter START.
- START: at cycle `CYCLES_PER_BIT/2` (250), sample the line. If it is low, continue. If it is high, treat it as a glitch: return to IDLE with no valid pulse and no flag change.
- Each subsequent bit is sampled `CYCLES_PER_BIT` cycles after the previous sample, i.e. at mid-bit. Bits shift into the payload LSB first: data[0..7], then parity, then stop1 and stop2.
- After the stop2 sample, enter DONE for one cycle. In DONE:
  - load `uart_rx_data` with the payload;
  - `uart_rx_pe` = parity bit XOR (XOR of data bits), so an odd count of ones across data and parity is an error;
  - `uart_rx_fe` = NOT (stop1 AND stop2);
  - `uart_rx_break` = the whole payload is zero;
  - pulse `uart_rx_valid`;
  - return to IDLE.
- `uart_rx_data`, `uart_rx_pe`, `uart_rx_fe` and `uart_rx_break` hold their values until the next DONE. They are not cleared by IDLE, glitches or `uart_rx_en`.
- A break frame also sets `uart_rx_fe`.
- After a break, IDLE waits for the line to return high before arming for a new falling edge.
- If `uart_rx_en` is deasserted in any non-IDLE state, the frame aborts: return to IDLE next cycle, with no valid pulse and outputs unchanged.
- A falling edge inside a frame is ignored; there is no resynchronisation mid-frame.

## Timing
- Reset values: `uart_rx_data`=0, `uart_rx_valid`=0, `uart_rx_pe`=0, `uart_rx_fe`=0, `uart_rx_break`=0. FSM in IDLE, synchroniser flops set to 1.
- Latency: `uart_rx_valid` rises about 11.5 bit times plus 3 cycles after the start-bit falling edge (≈115 µs at the default parameters). New outputs are therefore stable before the end of the second stop bit.
- The FSM is back in IDLE before the end of stop2, so back-to-back frames with zero idle gap are received.
- Sample point tolerance is ±0.5 bit minus the synchroniser delay. Bit-counter arithmetic uses `clog2(CYCLES_PER_BIT)`-bit unsigned counters with no wrap within a bit.

## Test plan
- Valid frame: data 0x24, parity 0, stops 11, sent after ≥1 ms idle -> single `uart_rx_valid` pulse; `uart_rx_data`=0x624, pe=0, fe=0, break=0; value still held 1 µs after the frame ends.
- Odd-weight data: data 0x01, parity 1 -> data=0x701, pe=0. Then a frame with data 0x01, parity 0 -> data=0x601, pe=1, valid pulses.
- Frame error: data 0x55, parity 0, stop2=0 -> data=0x255, fe=1, pe=0.
- Break: line held low for 15 bit times -> data=0x000, break=1, fe=1, exactly one valid pulse, and no new frame until the line goes high and falls again.
- Glitch: 2 µs low pulse on an idle line, then a frame 0x24 sent 20 µs later -> no valid for the glitch; the following frame is received as 0x624.
- Four back-to-back random frames with a 1-bit idle gap, plus one `uart_rx_en`=0 pulse mid-frame -> all unaborted frames match exactly; the aborted frame produces no valid pulse; an async `resetn` mid-frame returns every output to 0 immediately.

Source files
------------

// File: rtl/sbus_uart_rx.sv
// S.Bus UART receiver: 8E2 frames, idle-high line.
// Raw 11-bit payload with parity, frame and break flags.
module sbus_uart_rx #(
  parameter int BIT_RATE     = 100000,
  parameter int CLK_HZ       = 50000000,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_BIT   = 1,
  parameter int STOP_BITS    = 2,
  parameter int PAYLOAD_BITS = DATA_BITS + PARITY_BIT + STOP_BITS
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_en,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data,
  output logic                    uart_rx_valid,
  output logic                    uart_rx_pe,
  output logic                    uart_rx_fe,
  output logic                    uart_rx_break
);

  localparam int CPB  = CLK_HZ / BIT_RATE;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB);
  localparam int BW   = $clog2(PAYLOAD_BITS + 1);
  localparam int DP   = DATA_BITS + PARITY_BIT;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_DONE
  } state_t;

  state_t state, state_n;

  logic rxd_s1, rxd_s2, rxd_q;
  logic fall;
  logic [CW-1:0] cyc_cnt;
  logic [BW-1:0] bit_cnt;
  logic [PAYLOAD_BITS-1:0] payload;
  logic tick_half, tick_full;
  logic cyc_clr, bit_clr, shift, load;

  assign fall      = rxd_q & ~rxd_s2;
  assign tick_half = (cyc_cnt == CW'(HALF - 1));
  assign tick_full = (cyc_cnt == CW'(CPB - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rxd_s1 <= 1'b1;
      rxd_s2 <= 1'b1;
      rxd_q  <= 1'b1;
    end else begin
      rxd_s1 <= uart_rxd;
      rxd_s2 <= rxd_s1;
      rxd_q  <= rxd_s2;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    cyc_clr = 1'b0;
    bit_clr = 1'b0;
    shift   = 1'b0;
    load    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (fall && uart_rx_en) begin
          state_n = S_START;
          cyc_clr = 1'b1;
          bit_clr = 1'b1;
        end
      end
      S_START: begin
        if (tick_half) begin
          cyc_clr = 1'b1;
          state_n = rxd_s2 ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (tick_full) begin
          cyc_clr = 1'b1;
          shift   = 1'b1;
          if (bit_cnt == BW'(DATA_BITS - 1)) begin
            state_n = S_PARITY;
            bit_clr = 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (tick_full) begin
          cyc_clr = 1'b1;
          shift   = 1'b1;
          bit_clr = 1'b1;
          state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (tick_full) begin
          cyc_clr = 1'b1;
          shift   = 1'b1;
          if (bit_cnt == BW'(STOP_BITS - 1))
            state_n = S_DONE;
        end
      end
      S_DONE: begin
        load    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    // Dropping enable abandons the frame without touching outputs
    if (state != S_IDLE && !uart_rx_en) begin
      state_n = S_IDLE;
      shift   = 1'b0;
      load    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cyc_cnt <= '0;
      bit_cnt <= '0;
      payload <= '0;
    end else begin
      if (cyc_clr)
        cyc_cnt <= '0;
      else if (state != S_IDLE && state != S_DONE)
        cyc_cnt <= cyc_cnt + 1'b1;
      if (bit_clr)
        bit_cnt <= '0;
      else if (shift)
        bit_cnt <= bit_cnt + 1'b1;
      if (shift)
        payload <= {rxd_s2, payload[PAYLOAD_BITS-1:1]};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      uart_rx_data  <= '0;
      uart_rx_valid <= 1'b0;
      uart_rx_pe    <= 1'b0;
      uart_rx_fe    <= 1'b0;
      uart_rx_break <= 1'b0;
    end else begin
      uart_rx_valid <= load;
      if (load) begin
        uart_rx_data  <= payload;
        uart_rx_pe    <= ^payload[DP-1:0];
        uart_rx_fe    <= ~&payload[PAYLOAD_BITS-1:DP];
        uart_rx_break <= ~|payload;
      end
    end
  end

endmodule

// File: tb/tb_sbus_uart_rx.sv
// Bench for sbus_uart_rx: serial stimulus tasks
// with a queue-based scoreboard on uart_rx_valid.
`timescale 1ns/1ps
module tb_sbus_uart_rx;

  localparam int CLK_HZ = 10000000;
  localparam int BIT_NS = 10000;
  localparam int CLK_HP = 50;

  logic        clk;
  logic        resetn;
  logic        uart_rxd;
  logic        uart_rx_en;
  logic [10:0] uart_rx_data;
  logic        uart_rx_valid;
  logic        uart_rx_pe;
  logic        uart_rx_fe;
  logic        uart_rx_break;

  sbus_uart_rx #(
    .BIT_RATE(100000),
    .CLK_HZ  (CLK_HZ)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .uart_rxd     (uart_rxd),
    .uart_rx_en   (uart_rx_en),
    .uart_rx_data (uart_rx_data),
    .uart_rx_valid(uart_rx_valid),
    .uart_rx_pe   (uart_rx_pe),
    .uart_rx_fe   (uart_rx_fe),
    .uart_rx_break(uart_rx_break)
  );

  typedef struct {
    logic [10:0] d;
    logic        pe;
    logic        fe;
    logic        brk;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   vcount   = 0;

  initial clk = 1'b0;
  always #(CLK_HP) clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (resetn && uart_rx_valid) begin
      vcount++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_valid got data=%h", uart_rx_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({uart_rx_data, uart_rx_pe, uart_rx_fe, uart_rx_break} !==
            {e.d, e.pe, e.fe, e.brk}) begin
          failures++;
          $display("FAIL frame got d=%h pe=%b fe=%b brk=%b want d=%h pe=%b fe=%b brk=%b",
                   uart_rx_data, uart_rx_pe, uart_rx_fe, uart_rx_break,
                   e.d, e.pe, e.fe, e.brk);
        end
      end
    end
  end

  function automatic exp_t model(input logic [10:0] pl);
    exp_t e;
    e.d   = pl;
    e.pe  = ^pl[8:0];
    e.fe  = ~(pl[9] & pl[10]);
    e.brk = (pl == 11'h000);
    return e;
  endfunction

  task automatic send_frame(input logic [10:0] pl, input int gap_bits,
                            input int abort_bit);
    if (abort_bit < 0) exp_q.push_back(model(pl));
    uart_rxd = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 11; i++) begin
      uart_rxd = pl[i];
      if (i == abort_bit) begin
        #(BIT_NS / 4);
        uart_rx_en = 1'b0;
        #(500);
        uart_rx_en = 1'b1;
        #(BIT_NS * 3 / 4 - 500);
      end else begin
        #(BIT_NS);
      end
    end
    uart_rxd = 1'b1;
    #(gap_bits * BIT_NS);
  endtask

  task automatic test_reset;
    resetn     = 1'b0;
    uart_rxd   = 1'b1;
    uart_rx_en = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if ({uart_rx_data, uart_rx_valid, uart_rx_pe, uart_rx_fe, uart_rx_break} !== 15'h0) begin
      failures++;
      $display("FAIL reset_state got d=%h v=%b pe=%b fe=%b brk=%b want all 0",
               uart_rx_data, uart_rx_valid, uart_rx_pe, uart_rx_fe, uart_rx_break);
    end
    resetn = 1'b1;
    #(1000000);
  endtask

  task automatic test_valid_frame;
    send_frame(11'h624, 0, -1);
    #(1000);
    checks++;
    if (uart_rx_data !== 11'h624 || uart_rx_fe !== 1'b0) begin
      failures++;
      $display("FAIL hold_after_frame got d=%h fe=%b want d=624 fe=0",
               uart_rx_data, uart_rx_fe);
    end
    #(2 * BIT_NS);
  endtask

  task automatic test_parity;
    send_frame(11'h701, 2, -1);
    send_frame(11'h601, 2, -1);
    checks++;
    if (uart_rx_pe !== 1'b1) begin
      failures++;
      $display("FAIL parity_error got pe=%b want 1", uart_rx_pe);
    end
  endtask

  task automatic test_frame_error;
    send_frame(11'h255, 2, -1);
    checks++;
    if (uart_rx_fe !== 1'b1 || uart_rx_pe !== 1'b0) begin
      failures++;
      $display("FAIL frame_error got fe=%b pe=%b want fe=1 pe=0",
               uart_rx_fe, uart_rx_pe);
    end
  endtask

  task automatic test_break;
    int v0;
    v0 = vcount;
    exp_q.push_back(model(11'h000));
    uart_rxd = 1'b0;
    #(20 * BIT_NS);
    checks++;
    if (vcount - v0 != 1) begin
      failures++;
      $display("FAIL break_pulses got %0d want 1", vcount - v0);
    end
    checks++;
    if (uart_rx_break !== 1'b1 || uart_rx_fe !== 1'b1) begin
      failures++;
      $display("FAIL break_flags got brk=%b fe=%b want 1 1",
               uart_rx_break, uart_rx_fe);
    end
    uart_rxd = 1'b1;
    #(2 * BIT_NS);
    send_frame(11'h6a5, 2, -1);
    checks++;
    if (uart_rx_break !== 1'b0) begin
      failures++;
      $display("FAIL break_clear got brk=%b want 0", uart_rx_break);
    end
  endtask

  task automatic test_glitch;
    int v0;
    v0 = vcount;
    uart_rxd = 1'b0;
    #(2000);
    uart_rxd = 1'b1;
    #(20000);
    checks++;
    if (vcount != v0) begin
      failures++;
      $display("FAIL glitch_valid got %0d pulses want 0", vcount - v0);
    end
    send_frame(11'h624, 2, -1);
  endtask

  task automatic test_back_to_back;
    logic [10:0] pl;
    logic [10:0] last;
    last = '0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        send_frame(11'h7ff, 1, 3);
        checks++;
        if (uart_rx_data !== last) begin
          failures++;
          $display("FAIL abort_hold got d=%h want %h", uart_rx_data, last);
        end
      end else begin
        pl = {2'b11, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255))};
        send_frame(pl, 1, -1);
        last = pl;
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    uart_rxd = 1'b0;
    #(BIT_NS);
    uart_rxd = 1'b1;
    #(3 * BIT_NS);
    #(BIT_NS / 3);
    resetn = 1'b0;
    #1;
    checks++;
    if ({uart_rx_data, uart_rx_valid, uart_rx_pe, uart_rx_fe, uart_rx_break} !== 15'h0) begin
      failures++;
      $display("FAIL async_reset got d=%h v=%b pe=%b fe=%b brk=%b want all 0",
               uart_rx_data, uart_rx_valid, uart_rx_pe, uart_rx_fe, uart_rx_break);
    end
    #(5 * BIT_NS);
    resetn = 1'b1;
    #(2 * BIT_NS);
    send_frame(11'h624, 2, -1);
  endtask

  initial begin
    test_reset();
    test_valid_frame();
    test_parity();
    test_frame_error();
    test_break();
    test_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    #(2 * BIT_NS);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_frames got %0d pending want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
